// File: rtl/stream_demux.sv
// One-input, two-output stream demultiplexer. Each output owns a single
// holding register and a 16-bit delivery counter.
module stream_demux #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_select_b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [15:0]      a_count,
    output logic [15:0]      b_count
);

    logic [WIDTH-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
    logic             a_full_q, a_full_d, b_full_q, b_full_d;
    logic [15:0]      a_count_q, a_count_d, b_count_q, b_count_d;
    logic             sel_full, sel_ready, load_a, load_b;

    always_comb begin
        sel_full  = in_select_b ? b_full_q : a_full_q;
        sel_ready = in_select_b ? b_ready  : a_ready;
        // A draining register accepts a replacement in the same cycle.
        in_ready  = ~sel_full | sel_ready;

        load_a = in_valid & in_ready & ~in_select_b;
        load_b = in_valid & in_ready &  in_select_b;

        a_full_d  = load_a | (a_full_q & ~a_ready);
        b_full_d  = load_b | (b_full_q & ~b_ready);
        a_data_d  = load_a ? in_data : a_data_q;
        b_data_d  = load_b ? in_data : b_data_q;
        a_count_d = a_count_q + {15'd0, a_full_q & a_ready};
        b_count_d = b_count_q + {15'd0, b_full_q & b_ready};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_data_q  <= '0;
            b_data_q  <= '0;
            a_full_q  <= 1'b0;
            b_full_q  <= 1'b0;
            a_count_q <= '0;
            b_count_q <= '0;
        end else begin
            a_data_q  <= a_data_d;
            b_data_q  <= b_data_d;
            a_full_q  <= a_full_d;
            b_full_q  <= b_full_d;
            a_count_q <= a_count_d;
            b_count_q <= b_count_d;
        end
    end

    assign a_data  = a_data_q;
    assign b_data  = b_data_q;
    assign a_valid = a_full_q;
    assign b_valid = b_full_q;
    assign a_count = a_count_q;
    assign b_count = b_count_q;

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter: WIDTH, default 32, data path width in bits.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_data  input  WIDTH  word offered by the upstream source.
REQ-005 Port: in_select_b  input  1  route selection: 0 routes to port A, 1 routes to port B.
REQ-006 Port: in_valid  input  1  in_data and in_select_b are valid.
REQ-007 Port: in_ready  output  1  the demux accepts the offered word this cycle.
REQ-008 Port: a_data  output  WIDTH  word held for port A.
REQ-009 Port: a_valid  output  1  a_data is valid.
REQ-010 Port: a_ready  input  1  the port A consumer accepts a_data.
REQ-011 Port: b_data  output  WIDTH  word held for port B.
REQ-012 Port: b_valid  output  1  b_data is valid.
REQ-013 Port: b_ready  input  1  the port B consumer accepts b_data.
REQ-014 Port: a_count  output  16  count of words delivered on port A.
REQ-015 Port: b_count  output  16  count of words delivered on port B.

Function
REQ-016 Each output port SHALL own one holding register (data plus full flag); a_valid equals full_A and b_valid equals full_B.
REQ-017 Input transfer: occurs when in_valid=1 and in_ready=1 at a clock edge.
REQ-018 Output transfer: occurs when x_valid=1 and x_ready=1 at a clock edge, where x is a or b.
REQ-019 in_ready SHALL be computed combinationally as (~full_sel | sel_ready), where sel is the port chosen by in_select_b; it SHALL not depend on in_valid.
REQ-020 On an input transfer, in_data SHALL load the selected port's register and set its full flag; the word appears on x_data and x_valid=1 in the next cycle (latency 1 cycle).
REQ-021 The unselected port's register, full flag, and counter SHALL be unaffected by an input transfer.
REQ-022 On an output transfer with no simultaneous load to that port, that port's full flag SHALL clear at the edge.
REQ-023 On a simultaneous output transfer and load to the same port, full SHALL remain 1 and the new word SHALL replace the old one, with no bubble cycle (full throughput).
REQ-024 While x_valid=1 and x_ready=0, x_data SHALL be held stable and x_valid SHALL remain 1.
REQ-025 Words routed to the same port SHALL be delivered in acceptance order; no ordering is guaranteed between ports.
REQ-026 A stalled port SHALL NOT block input transfers routed to the other port.
REQ-027 When in_valid=0, in_select_b and in_data SHALL be ignored, including X values.
REQ-028 On each output transfer, that port's counter SHALL increment by 1, modulo 2^16; 16'hFFFF SHALL wrap to 16'h0000.
REQ-029 Both ports MAY complete output transfers in the same cycle; the two counters update independently.
REQ-030 A word SHALL never be duplicated, dropped, or delivered to the unselected port.

Reset
REQ-031 While rst=1 at an edge, full_A and full_B SHALL be cleared to 0, a_data and b_data to 0, and a_count and b_count to 0.
REQ-032 rst SHALL take priority over any simultaneous input or output transfer; held words SHALL be discarded.
REQ-033 During reset, in_ready SHALL still follow REQ-019. With both registers empty after reset, in_ready is 1, but no word loads while rst=1.
REQ-034 In the first cycle after rst deasserts, a_valid=0, b_valid=0, and in_ready=1.

Verification
REQ-035 Reset, then a single word 0xDEADBEEF with in_select_b=0, with a_ready=0 -> the next cycle shows a_valid=1 and a_data=0xDEADBEEF, held stable for 5 cycles; b_valid stays 0 and a_count stays 0.
REQ-036 Port A full with a_ready=0, then offer 0x12345678 with in_select_b=0 -> in_ready=0. Offer the same word with in_select_b=1 -> in_ready=1, and the next cycle shows b_data=0x12345678.
REQ-037 Stream values 1..100 alternating select with a_ready=b_ready=1 every cycle -> one word accepted per cycle, port A receives the odd values and port B the even values in order, and a_count=b_count=50.
REQ-038 Preload a_count to 0xFFFE via 0xFFFE port A transfers, then make 2 more -> a_count reads 0xFFFF, then 0x0000; b_count stays 0.
REQ-039 Both ports full, assert rst for one cycle while in_valid=1, a_ready=1, and b_ready=1 -> after the edge, a_valid=b_valid=0, both data outputs are 0, both counters are 0, and no count increment occurs.
REQ-040 Random in_valid, in_select_b, a_ready, and b_ready for 10k cycles, checked against a per-port reference queue -> no loss, duplication, or misrouting; x_data stable under stall; counters equal the scoreboard delivery counts.
